axi_rd_arb2: RTL and testbench

AXI_RD_ARB2 -- requirements
Module: axi_rd_arb2

---
 rtl/axi_rd_arb2.sv | 204 ++++++++++++++++++++
 tb/tb_axi_rd_arb2.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb2.sv
// Two-requester AXI read-channel arbiter with a single outstanding transaction.
// Round-robin grant in IDLE, then AR pass-through (ADDR), then R pass-through (DATA) to rlast.
module axi_rd_arb2 #(
   parameter int P_AXI_IDWIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [P_AXI_IDWIDTH-1:0] axis0_arid,
   input  logic [31:0]              axis0_araddr,
   input  logic [3:0]               axis0_arlen,
   input  logic [2:0]               axis0_arsize,
   input  logic [1:0]               axis0_arburst,
   input  logic                     axis0_arlock,
   input  logic [3:0]               axis0_arcache,
   input  logic [2:0]               axis0_arprot,
   input  logic                     axis0_aruser,
   input  logic                     axis0_arvalid,
   output logic                     axis0_arready,
   output logic [P_AXI_IDWIDTH-1:0] axis0_rid,
   output logic [63:0]              axis0_rdata,
   output logic [1:0]               axis0_rresp,
   output logic                     axis0_rlast,
   output logic                     axis0_ruser,
   output logic                     axis0_rvalid,
   input  logic                     axis0_rready,
   input  logic [P_AXI_IDWIDTH-1:0] axis1_arid,
   input  logic [31:0]              axis1_araddr,
   input  logic [3:0]               axis1_arlen,
   input  logic [2:0]               axis1_arsize,
   input  logic [1:0]               axis1_arburst,
   input  logic                     axis1_arlock,
   input  logic [3:0]               axis1_arcache,
   input  logic [2:0]               axis1_arprot,
   input  logic                     axis1_aruser,
   input  logic                     axis1_arvalid,
   output logic                     axis1_arready,
   output logic [P_AXI_IDWIDTH-1:0] axis1_rid,
   output logic [63:0]              axis1_rdata,
   output logic [1:0]               axis1_rresp,
   output logic                     axis1_rlast,
   output logic                     axis1_ruser,
   output logic                     axis1_rvalid,
   input  logic                     axis1_rready,
   output logic [P_AXI_IDWIDTH-1:0] axim_arid,
   output logic [31:0]              axim_araddr,
   output logic [3:0]               axim_arlen,
   output logic [2:0]               axim_arsize,
   output logic [1:0]               axim_arburst,
   output logic                     axim_arlock,
   output logic [3:0]               axim_arcache,
   output logic [2:0]               axim_arprot,
   output logic                     axim_aruser,
   output logic                     axim_arvalid,
   input  logic                     axim_arready,
   input  logic [P_AXI_IDWIDTH-1:0] axim_rid,
   input  logic [63:0]              axim_rdata,
   input  logic [1:0]               axim_rresp,
   input  logic                     axim_rlast,
   input  logic                     axim_ruser,
   input  logic                     axim_rvalid,
   output logic                     axim_rready,
   output logic [1:0]               gnt,
   output logic                     busy,
   output logic                     err_rlast
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t     r_state, w_next;
   logic [1:0] r_gnt;
   logic       r_last;
   logic [3:0] r_len_q, r_beat;
   logic       r_err;
   logic       w_req, w_pick1, w_ar_hs, w_beat, w_done;

   // r_last holds the index of the previously granted requester; on a tie the other one wins.
   assign w_req   = axis0_arvalid | axis1_arvalid;
   assign w_pick1 = axis1_arvalid & (~axis0_arvalid | ~r_last);
   assign w_ar_hs = (r_state == S_ADDR) & axim_arready;
   assign w_beat  = (r_state == S_DATA) & axim_rvalid & axim_rready;
   assign w_done  = w_beat & axim_rlast;

   assign gnt       = r_gnt;
   assign busy      = (r_state != S_IDLE);
   assign err_rlast = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req)   w_next = S_ADDR;
         S_ADDR:  if (w_ar_hs) w_next = S_DATA;
         S_DATA:  if (w_done)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt   <= 2'b00;
         r_last  <= 1'b1;
         r_len_q <= 4'd0;
         r_beat  <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_req) begin
            r_gnt <= w_pick1 ? 2'b10 : 2'b01;
         end else if (w_done) begin
            r_gnt  <= 2'b00;
            r_last <= r_gnt[1];
         end
         if (w_ar_hs) begin
            r_len_q <= axim_arlen;
            r_beat  <= 4'd0;
         end else if (w_beat) begin
            r_beat <= r_beat + 4'd1;
         end
         // rlast must land exactly on beat index len_q; early or missing rlast is flagged
         if (w_beat && (axim_rlast != (r_beat == r_len_q))) r_err <= 1'b1;
      end
   end

   always_comb begin
      axim_arid     = '0;
      axim_araddr   = '0;
      axim_arlen    = '0;
      axim_arsize   = '0;
      axim_arburst  = '0;
      axim_arlock   = 1'b0;
      axim_arcache  = '0;
      axim_arprot   = '0;
      axim_aruser   = 1'b0;
      axim_arvalid  = 1'b0;
      axim_rready   = 1'b0;
      axis0_arready = 1'b0;
      axis1_arready = 1'b0;
      axis0_rid     = '0;
      axis0_rdata   = '0;
      axis0_rresp   = '0;
      axis0_rlast   = 1'b0;
      axis0_ruser   = 1'b0;
      axis0_rvalid  = 1'b0;
      axis1_rid     = '0;
      axis1_rdata   = '0;
      axis1_rresp   = '0;
      axis1_rlast   = 1'b0;
      axis1_ruser   = 1'b0;
      axis1_rvalid  = 1'b0;
      case (r_state)
         S_ADDR: begin
            // arvalid stays up for the whole ADDR phase even if the requester withdraws
            axim_arvalid = 1'b1;
            if (r_gnt[1]) begin
               axim_arid     = axis1_arid;
               axim_araddr   = axis1_araddr;
               axim_arlen    = axis1_arlen;
               axim_arsize   = axis1_arsize;
               axim_arburst  = axis1_arburst;
               axim_arlock   = axis1_arlock;
               axim_arcache  = axis1_arcache;
               axim_arprot   = axis1_arprot;
               axim_aruser   = axis1_aruser;
               axis1_arready = axim_arready;
            end else begin
               axim_arid     = axis0_arid;
               axim_araddr   = axis0_araddr;
               axim_arlen    = axis0_arlen;
               axim_arsize   = axis0_arsize;
               axim_arburst  = axis0_arburst;
               axim_arlock   = axis0_arlock;
               axim_arcache  = axis0_arcache;
               axim_arprot   = axis0_arprot;
               axim_aruser   = axis0_aruser;
               axis0_arready = axim_arready;
            end
         end
         S_DATA: begin
            if (r_gnt[1]) begin
               axis1_rid    = axim_rid;
               axis1_rdata  = axim_rdata;
               axis1_rresp  = axim_rresp;
               axis1_rlast  = axim_rlast;
               axis1_ruser  = axim_ruser;
               axis1_rvalid = axim_rvalid;
               axim_rready  = axis1_rready;
            end else begin
               axis0_rid    = axim_rid;
               axis0_rdata  = axim_rdata;
               axis0_rresp  = axim_rresp;
               axis0_rlast  = axim_rlast;
               axis0_ruser  = axim_ruser;
               axis0_rvalid = axim_rvalid;
               axim_rready  = axis0_rready;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Bench for axi_rd_arb2: per-scenario tasks plus an R-beat scoreboard
// filled when the downstream beat is driven and drained when a requester accepts it.
module tb_axi_rd_arb2;

   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] axis0_arid = '0, axis1_arid = '0;
   logic [31:0]   axis0_araddr = '0, axis1_araddr = '0;
   logic [3:0]    axis0_arlen = '0, axis1_arlen = '0;
   logic [2:0]    axis0_arsize = '0, axis1_arsize = '0;
   logic [1:0]    axis0_arburst = '0, axis1_arburst = '0;
   logic          axis0_arlock = 1'b0, axis1_arlock = 1'b0;
   logic [3:0]    axis0_arcache = '0, axis1_arcache = '0;
   logic [2:0]    axis0_arprot = '0, axis1_arprot = '0;
   logic          axis0_aruser = 1'b0, axis1_aruser = 1'b0;
   logic          axis0_arvalid = 1'b0, axis1_arvalid = 1'b0;
   logic          axis0_arready, axis1_arready;
   logic [IW-1:0] axis0_rid, axis1_rid;
   logic [63:0]   axis0_rdata, axis1_rdata;
   logic [1:0]    axis0_rresp, axis1_rresp;
   logic          axis0_rlast, axis1_rlast, axis0_ruser, axis1_ruser;
   logic          axis0_rvalid, axis1_rvalid;
   logic          axis0_rready = 1'b1, axis1_rready = 1'b1;
   logic [IW-1:0] axim_arid;
   logic [31:0]   axim_araddr;
   logic [3:0]    axim_arlen;
   logic [2:0]    axim_arsize;
   logic [1:0]    axim_arburst;
   logic          axim_arlock;
   logic [3:0]    axim_arcache;
   logic [2:0]    axim_arprot;
   logic          axim_aruser, axim_arvalid;
   logic          axim_arready = 1'b0;
   logic [IW-1:0] axim_rid = '0;
   logic [63:0]   axim_rdata = '0;
   logic [1:0]    axim_rresp = '0;
   logic          axim_rlast = 1'b0, axim_ruser = 1'b0, axim_rvalid = 1'b0;
   logic          axim_rready;
   logic [1:0]    gnt;
   logic          busy, err_rlast;

   int checks = 0;
   int errors = 0;
   int seq = 0;

   typedef logic [70:0] beat_t;   // {port, rid, rdata, rlast}
   beat_t exp_q[$];

   axi_rd_arb2 #(.P_AXI_IDWIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .axis0_arid(axis0_arid), .axis0_araddr(axis0_araddr), .axis0_arlen(axis0_arlen),
      .axis0_arsize(axis0_arsize), .axis0_arburst(axis0_arburst), .axis0_arlock(axis0_arlock),
      .axis0_arcache(axis0_arcache), .axis0_arprot(axis0_arprot), .axis0_aruser(axis0_aruser),
      .axis0_arvalid(axis0_arvalid), .axis0_arready(axis0_arready),
      .axis0_rid(axis0_rid), .axis0_rdata(axis0_rdata), .axis0_rresp(axis0_rresp),
      .axis0_rlast(axis0_rlast), .axis0_ruser(axis0_ruser), .axis0_rvalid(axis0_rvalid),
      .axis0_rready(axis0_rready),
      .axis1_arid(axis1_arid), .axis1_araddr(axis1_araddr), .axis1_arlen(axis1_arlen),
      .axis1_arsize(axis1_arsize), .axis1_arburst(axis1_arburst), .axis1_arlock(axis1_arlock),
      .axis1_arcache(axis1_arcache), .axis1_arprot(axis1_arprot), .axis1_aruser(axis1_aruser),
      .axis1_arvalid(axis1_arvalid), .axis1_arready(axis1_arready),
      .axis1_rid(axis1_rid), .axis1_rdata(axis1_rdata), .axis1_rresp(axis1_rresp),
      .axis1_rlast(axis1_rlast), .axis1_ruser(axis1_ruser), .axis1_rvalid(axis1_rvalid),
      .axis1_rready(axis1_rready),
      .axim_arid(axim_arid), .axim_araddr(axim_araddr), .axim_arlen(axim_arlen),
      .axim_arsize(axim_arsize), .axim_arburst(axim_arburst), .axim_arlock(axim_arlock),
      .axim_arcache(axim_arcache), .axim_arprot(axim_arprot), .axim_aruser(axim_aruser),
      .axim_arvalid(axim_arvalid), .axim_arready(axim_arready),
      .axim_rid(axim_rid), .axim_rdata(axim_rdata), .axim_rresp(axim_rresp),
      .axim_rlast(axim_rlast), .axim_ruser(axim_ruser), .axim_rvalid(axim_rvalid),
      .axim_rready(axim_rready),
      .gnt(gnt), .busy(busy), .err_rlast(err_rlast)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so the negedge sees one stable value per handshake cycle.
   always @(negedge clk) begin
      beat_t b, e;
      if (axis0_rvalid && axis0_rready) begin
         b = {1'b0, axis0_rid, axis0_rdata, axis0_rlast};
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_extra0 got=%h want=none", b);
         end else begin
            e = exp_q.pop_front();
            if (b !== e) begin errors++; $display("FAIL sb_beat0 got=%h want=%h", b, e); end
         end
      end
      if (axis1_rvalid && axis1_rready) begin
         b = {1'b1, axis1_rid, axis1_rdata, axis1_rlast};
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_extra1 got=%h want=none", b);
         end else begin
            e = exp_q.pop_front();
            if (b !== e) begin errors++; $display("FAIL sb_beat1 got=%h want=%h", b, e); end
         end
      end
   end

   task automatic do_reset;
      rst = 1'b1;
      axis0_arvalid = 1'b0; axis1_arvalid = 1'b0;
      axim_rvalid = 1'b0; axim_rlast = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_ar(input bit p, input logic [31:0] a, input logic [3:0] l, input logic v);
      if (p) begin
         axis1_arid = 5'h11; axis1_araddr = a; axis1_arlen = l;
         axis1_arsize = 3'd3; axis1_arburst = 2'b01; axis1_arvalid = v;
      end else begin
         axis0_arid = 5'h02; axis0_araddr = a; axis0_arlen = l;
         axis0_arsize = 3'd3; axis0_arburst = 2'b01; axis0_arvalid = v;
      end
   endtask

   // Drive n downstream beats for requester p, holding each until accepted.
   task automatic send_beats(input bit p, input int n, input bit last_final, input bit tog);
      int  wc;
      bit  ok;
      for (int i = 0; i < n; i++) begin
         axim_rvalid = 1'b1;
         axim_rid    = p ? 5'h11 : 5'h02;
         axim_rdata  = {32'hD00D_0000, seq};
         axim_rresp  = 2'b00;
         axim_ruser  = p;
         axim_rlast  = last_final && (i == n - 1);
         exp_q.push_back({p, axim_rid, axim_rdata, axim_rlast});
         seq++;
         wc = 0;
         do begin
            @(negedge clk) ok = axim_rready;
            @(posedge clk);
            #1;
            if (tog) axis1_rready = ~axis1_rready;
            wc++;
         end while (!ok && wc < 50);
         if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout got=no_rready want=rready port=%0d", p);
         end
      end
      axim_rvalid = 1'b0;
      axim_rlast  = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      axim_arready = 1'b1;
      #1;
      checks++;
      if ({gnt, busy, err_rlast, axim_arvalid, axim_rready, axis0_arready, axis1_arready,
           axis0_rvalid, axis1_rvalid} !== 10'b0) begin
         errors++;
         $display("FAIL reset_outs got=%b want=0", {gnt, busy, err_rlast, axim_arvalid,
                  axim_rready, axis0_arready, axis1_arready, axis0_rvalid, axis1_rvalid});
      end
   endtask

   task automatic test_single;
      axim_arready = 1'b1; axis0_rready = 1'b1; axis1_rready = 1'b1;
      set_ar(0, 32'h1000_0040, 4'd3, 1'b1);
      #1;
      checks++;
      if (axim_arvalid !== 1'b0) begin errors++; $display("FAIL single_early_arvalid got=%b want=0", axim_arvalid); end
      @(posedge clk); #1;
      checks++;
      if ({axim_arvalid, axim_araddr, gnt, busy, axis0_arready, axis1_arready} !== {1'b1, 32'h1000_0040, 2'b01, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_addr got=%b %h %b %b %b %b want=1 10000040 01 1 1 0",
                  axim_arvalid, axim_araddr, gnt, busy, axis0_arready, axis1_arready);
      end
      @(posedge clk); #1;
      set_ar(0, 32'h1000_0040, 4'd3, 1'b0);
      // Non-granted R outputs stay quiet while the granted one sees the beat.
      axis0_rready = 1'b0; axim_rvalid = 1'b1; axim_rdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      checks++;
      if ({axis0_rvalid, axis1_rvalid, axim_rready} !== 3'b100 || axis1_rdata !== 64'h0) begin
         errors++;
         $display("FAIL single_route got=%b%b%b d1=%h want=100 d1=0", axis0_rvalid, axis1_rvalid, axim_rready, axis1_rdata);
      end
      axim_rvalid = 1'b0; axis0_rready = 1'b1;
      send_beats(0, 4, 1'b1, 1'b0);
      checks++;
      if ({busy, gnt, err_rlast} !== 4'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL single_done got=%b%b%b q=%0d want=0000 q=0", busy, gnt, err_rlast, exp_q.size());
      end
   endtask

   task automatic test_contention;
      do_reset;
      axim_arready = 1'b1; axis0_rready = 1'b1; axis1_rready = 1'b1;
      set_ar(0, 32'hA000_0000, 4'd1, 1'b1);
      set_ar(1, 32'hB000_0000, 4'd1, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 2'b01 || axim_araddr !== 32'hA000_0000 || axis1_arready !== 1'b0) begin
         errors++; $display("FAIL cont_first got=%b %h %b want=01 a0000000 0", gnt, axim_araddr, axis1_arready);
      end
      @(posedge clk); #1;
      set_ar(0, 32'hA000_0000, 4'd1, 1'b0);
      send_beats(0, 2, 1'b1, 1'b0);
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0 || axis1_arready !== 1'b0) begin
         errors++; $display("FAIL cont_bubble got=%b %b %b want=00 0 0", gnt, busy, axis1_arready);
      end
      @(posedge clk); #1;
      checks++;
      if (gnt !== 2'b10 || axim_araddr !== 32'hB000_0000 || axis1_arready !== 1'b1) begin
         errors++; $display("FAIL cont_second got=%b %h %b want=10 b0000000 1", gnt, axim_araddr, axis1_arready);
      end
      @(posedge clk); #1;
      set_ar(1, 32'hB000_0000, 4'd1, 1'b0);
      send_beats(1, 2, 1'b1, 1'b0);
      set_ar(0, 32'hC000_0000, 4'd0, 1'b1);
      set_ar(1, 32'hD000_0000, 4'd0, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 2'b01 || axim_araddr !== 32'hC000_0000) begin
         errors++; $display("FAIL cont_alt got=%b %h want=01 c0000000", gnt, axim_araddr);
      end
      @(posedge clk); #1;
      set_ar(0, 32'hC000_0000, 4'd0, 1'b0);
      send_beats(0, 1, 1'b1, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 2'b10) begin errors++; $display("FAIL cont_alt2 got=%b want=10", gnt); end
      @(posedge clk); #1;
      set_ar(1, 32'hD000_0000, 4'd0, 1'b0);
      send_beats(1, 1, 1'b1, 1'b0);
      checks++;
      if (exp_q.size() != 0 || err_rlast !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL cont_end got=q%0d e%b b%b want=q0 e0 b0", exp_q.size(), err_rlast, busy);
      end
   endtask

   task automatic test_backpressure;
      axim_arready = 1'b0; axis1_rready = 1'b1;
      set_ar(1, 32'h2000_0100, 4'd3, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (axim_arvalid !== 1'b1 || axim_araddr !== 32'h2000_0100 || axim_arlen !== 4'd3 ||
             axis1_arready !== 1'b0 || gnt !== 2'b10) begin
            errors++;
            $display("FAIL bp_hold%0d got=%b %h %h %b %b want=1 20000100 3 0 10", i,
                     axim_arvalid, axim_araddr, axim_arlen, axis1_arready, gnt);
         end
         @(posedge clk); #1;
      end
      axim_arready = 1'b1;
      #1;
      checks++;
      if (axis1_arready !== 1'b1) begin errors++; $display("FAIL bp_ready got=%b want=1", axis1_arready); end
      @(posedge clk); #1;
      set_ar(1, 32'h2000_0100, 4'd3, 1'b0);
      send_beats(1, 4, 1'b1, 1'b1);
      axis1_rready = 1'b1;
      checks++;
      if (exp_q.size() != 0 || err_rlast !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_end got=q%0d e%b b%b want=q0 e0 b0", exp_q.size(), err_rlast, busy);
      end
   endtask

   task automatic test_len_err;
      do_reset;
      axim_arready = 1'b1; axis0_rready = 1'b1;
      set_ar(0, 32'h3000_0000, 4'd1, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_ar(0, 32'h3000_0000, 4'd1, 1'b0);
      send_beats(0, 1, 1'b1, 1'b0);
      checks++;
      if (err_rlast !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL len_early got=e%b b%b want=e1 b0", err_rlast, busy);
      end
      do_reset;
      #1;
      checks++;
      if (err_rlast !== 1'b0) begin errors++; $display("FAIL len_rst_clear got=%b want=0", err_rlast); end
      set_ar(0, 32'h3000_0080, 4'd0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_ar(0, 32'h3000_0080, 4'd0, 1'b0);
      send_beats(0, 1, 1'b0, 1'b0);
      checks++;
      if (err_rlast !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL len_missing got=e%b b%b want=e1 b1", err_rlast, busy);
      end
      send_beats(0, 1, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b0 || err_rlast !== 1'b1 || exp_q.size() != 0) begin
         errors++; $display("FAIL len_late_done got=b%b e%b q%0d want=b0 e1 q0", busy, err_rlast, exp_q.size());
      end
   endtask

   task automatic test_reset_data;
      do_reset;
      axim_arready = 1'b1; axis0_rready = 1'b1; axis1_rready = 1'b1;
      set_ar(0, 32'h4000_0000, 4'd3, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_ar(0, 32'h4000_0000, 4'd3, 1'b0);
      send_beats(0, 2, 1'b0, 1'b0);
      axim_rvalid = 1'b1; axim_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      rst = 1'b1;
      #1;
      checks++;
      if ({axis0_rvalid, axis1_rvalid, gnt, busy, axim_rready, axim_arvalid, axis0_arready} !== 8'b0 ||
          axis0_rdata !== 64'h0) begin
         errors++;
         $display("FAIL rst_data got=%b d0=%h want=0", {axis0_rvalid, axis1_rvalid, gnt, busy,
                  axim_rready, axim_arvalid, axis0_arready}, axis0_rdata);
      end
      @(posedge clk); #1;
      axim_rvalid = 1'b0;
      rst = 1'b0;
      set_ar(1, 32'h5000_0000, 4'd0, 1'b1);
      #1;
      checks++;
      if (gnt !== 2'b00) begin errors++; $display("FAIL rst_post_idle got=%b want=00", gnt); end
      @(posedge clk); #1;
      checks++;
      if (gnt !== 2'b10 || axim_araddr !== 32'h5000_0000 || err_rlast !== 1'b0) begin
         errors++; $display("FAIL rst_post_gnt got=%b %h %b want=10 50000000 0", gnt, axim_araddr, err_rlast);
      end
      @(posedge clk); #1;
      set_ar(1, 32'h5000_0000, 4'd0, 1'b0);
      send_beats(1, 1, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b0 || err_rlast !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL rst_post_done got=b%b e%b q%0d want=b0 e0 q0", busy, err_rlast, exp_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_contention;
      test_backpressure;
      test_len_err;
      test_reset_data;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
